program_counter_unit: RTL and testbench
=======================================

# program_counter_unit

Sequential program-counter stage directly downstream of the per-class instruction decoders (B.cond, B, CBZ, data-processing, load/store). It consumes the selected control word's program-counter fields, the sign-extended 64-bit constant, and the condition field. It holds the PC register and the architectural NZCV flags register, and resolves conditional branches against the registered flags. It returns the packed 5-bit `status` that every decoder takes as input.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value after reset.
- `PC_STEP`, default 64'd4: sequential increment.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; sampled on `clock` rising edge.
- `function_select`  in  2  00 hold, 01 increment, 10 load, 11 conditional branch.
- `input_select`  in  1  branch target source: 0 = `databus_in`, 1 = PC + (`constant` << 2).
- `databus_enable`  in  1  drive PC+4 (link value) on `databus_out`.
- `constant`  in  64  sign-extended word offset from the active decoder.
- `condition`  in  4  instruction[3:0], meaningful only when `function_select`=11.
- `databus_in`  in  64  register-sourced target (BR).
- `status_load`  in  1  latch `alu_flags` into the flags register.
- `alu_flags`  in  4  {N,Z,C,V} from the ALU, current cycle.
- `alu_zero`  in  1  live ALU zero, used for CBZ/CBNZ by the decoders.
- `pc`  out  64  current PC, registered.
- `databus_out`  out  64  PC + `PC_STEP`, combinational from `pc`.
- `databus_out_valid`  out  1  equals `databus_enable`.
- `status`  out  5  {V,C,N,Z,alu_zero}: bits [4:1] registered, bit [0] live pass-through.
- `branch_taken`  out  1  registered; 1 for the cycle after a PC update other than increment or hold.

## Operation
- Reset (`reset`=0 at an edge): `pc`←`RESET_PC`, flags←0000, `branch_taken`←0. Reset overrides all other inputs in the same cycle.
- PC next-value:
  - 00: `pc` unchanged.
  - 01: `pc` + `PC_STEP`.
  - 10: target.
  - 11: target if `cond_true`, else `pc` + `PC_STEP`.
- Target: `input_select`=1 gives `pc` + (`constant` << 2), with the 64-bit shift dropping the top 2 bits. `input_select`=0 gives `databus_in`.
- All adds are modulo 2^64. Wrap from 64'hFFFF_FFFF_FFFF_FFFC by +4 gives 0, with no error indication.
- `cond_true` (LEGv8 encoding, evaluated on registered flags):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V)).
  - E and F: always true.
- Flags register: loads `alu_flags` at the edge when `status_load`=1, otherwise holds.
- Simultaneous `status_load` and `function_select`=11 in one cycle: the condition uses the old flags. The new flags are visible from the next cycle.
- `branch_taken`: set to 1 when the committed next-PC came from the target path, otherwise 0.

## Timing
- PC and flags update at the rising edge after the inputs are presented; there is one cycle of latency from the control word to `pc`.
- `databus_out` and `status[0]` are combinational. All other outputs are registered.
- No handshake: the control word is assumed valid every cycle. Hold (00) is the stall mechanism.
- Reset asserted mid-branch: the branch is discarded and `pc`=`RESET_PC` on the next cycle.

## Structure
- Shared package `control_unit_pkg` holds:
  - the function-select constants `PC_HOLD`, `PC_INC`, `PC_LOAD`, `PC_COND`;
  - the 4-bit condition-code constants EQ…NV;
  - the `status` bit-index constants, reused by all decoders.
- One sub-module, `condition_evaluator`: purely combinational, takes (condition[3:0], flags[3:0]) and produces `cond_true`, so it can be exhaustively tested on its own.

## Test plan
- Reset then four cycles of 01: `pc` reads 0, 4, 8, 12, 16; `branch_taken` stays 0.
- Load flags Z=1 via `status_load`, then next cycle 11, cond=0 (EQ), `input_select`=1, constant=-2: from pc=0x100, `pc` goes to 0xF8 and `branch_taken`=1. Repeat with cond=1 (NE): `pc` goes to 0x104 and `branch_taken`=0.
- Same-cycle `status_load` with Z=1 from old Z=0, plus 11 with EQ: not taken (pc+4). The next cycle shows `status[1]`=1.
- All 16 condition codes × 16 flag values through `condition_evaluator`, checked against the equations above; E and F always true.
- 10 with `input_select`=0 and `databus_in`=0xDEAD_BEE0: `pc` becomes 0xDEAD_BEE0 and `branch_taken`=1. `databus_enable`=1 at pc=0x40 gives `databus_out`=0x44.
- pc=64'hFFFF_FFFF_FFFF_FFFC with 01 wraps to 0. Reset asserted during a taken 11 yields `RESET_PC` and flags 0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared control-unit constants: PC function selects, condition codes, status bit positions.
package control_unit_pkg;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned FLAGS_W  = 4;
    localparam int unsigned STATUS_W = 5;
    localparam int unsigned COND_W   = 4;
    localparam int unsigned FSEL_W   = 2;

    // PC function select
    localparam logic [FSEL_W-1:0] PC_HOLD = 2'b00;
    localparam logic [FSEL_W-1:0] PC_INC  = 2'b01;
    localparam logic [FSEL_W-1:0] PC_LOAD = 2'b10;
    localparam logic [FSEL_W-1:0] PC_COND = 2'b11;

    // LEGv8 condition codes (instruction[3:0] of B.cond)
    localparam logic [COND_W-1:0] EQ = 4'h0;
    localparam logic [COND_W-1:0] NE = 4'h1;
    localparam logic [COND_W-1:0] HS = 4'h2;
    localparam logic [COND_W-1:0] LO = 4'h3;
    localparam logic [COND_W-1:0] MI = 4'h4;
    localparam logic [COND_W-1:0] PL = 4'h5;
    localparam logic [COND_W-1:0] VS = 4'h6;
    localparam logic [COND_W-1:0] VC = 4'h7;
    localparam logic [COND_W-1:0] HI = 4'h8;
    localparam logic [COND_W-1:0] LS = 4'h9;
    localparam logic [COND_W-1:0] GE = 4'hA;
    localparam logic [COND_W-1:0] LT = 4'hB;
    localparam logic [COND_W-1:0] GT = 4'hC;
    localparam logic [COND_W-1:0] LE = 4'hD;
    localparam logic [COND_W-1:0] AL = 4'hE;
    localparam logic [COND_W-1:0] NV = 4'hF;

    // Bit positions inside the 5-bit status word fed back to the decoders
    localparam int unsigned STATUS_ALU_ZERO = 0;
    localparam int unsigned STATUS_Z        = 1;
    localparam int unsigned STATUS_N        = 2;
    localparam int unsigned STATUS_C        = 3;
    localparam int unsigned STATUS_V        = 4;

    // Architectural flags in ALU order {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/program_counter_unit_condition_evaluator.sv
// Combinational LEGv8 condition-code resolution against a {N,Z,C,V} flag word.
module condition_evaluator
    import control_unit_pkg::*;
(
    input  logic [COND_W-1:0]  condition,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_true
);

    flags_t f;
    logic   ge;
    logic   hi;

    assign f  = flags_t'(flags);
    assign ge = (f.n == f.v);
    assign hi = f.c & ~f.z;

    // Decode the condition field; AL and NV are both unconditional
    always_comb begin
        cond_true = 1'b1;
        case (condition)
            EQ:      cond_true = f.z;
            NE:      cond_true = ~f.z;
            HS:      cond_true = f.c;
            LO:      cond_true = ~f.c;
            MI:      cond_true = f.n;
            PL:      cond_true = ~f.n;
            VS:      cond_true = f.v;
            VC:      cond_true = ~f.v;
            HI:      cond_true = hi;
            LS:      cond_true = ~hi;
            GE:      cond_true = ge;
            LT:      cond_true = ~ge;
            GT:      cond_true = ~f.z & ge;
            LE:      cond_true = ~(~f.z & ge);
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/program_counter_unit.sv
// PC register, NZCV flags register and conditional-branch resolution.
module program_counter_unit
    import control_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [FSEL_W-1:0]   function_select,
    input  logic                input_select,
    input  logic                databus_enable,
    input  logic [ADDR_W-1:0]   constant,
    input  logic [COND_W-1:0]   condition,
    input  logic [ADDR_W-1:0]   databus_in,
    input  logic                status_load,
    input  logic [FLAGS_W-1:0]  alu_flags,
    input  logic                alu_zero,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   databus_out,
    output logic                databus_out_valid,
    output logic [STATUS_W-1:0] status,
    output logic                branch_taken
);

    flags_t              flags;
    logic                cond_true;
    logic [ADDR_W-1:0]   pc_seq;
    logic [ADDR_W-1:0]   pc_rel;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   next_pc;
    logic                next_taken;

    // Condition is always judged on the registered flags, never on alu_flags
    condition_evaluator u_cond (
        .condition (condition),
        .flags     (flags),
        .cond_true (cond_true)
    );

    // Sequential and branch-target address arithmetic, all modulo 2^64
    assign pc_seq = pc + PC_STEP;
    assign pc_rel = pc + {constant[ADDR_W-3:0], 2'b00};
    assign target = input_select ? pc_rel : databus_in;

    // Next-PC selection and whether it came from the target path
    always_comb begin
        next_pc    = pc;
        next_taken = 1'b0;
        case (function_select)
            PC_HOLD: next_pc = pc;
            PC_INC:  next_pc = pc_seq;
            PC_LOAD: begin
                next_pc    = target;
                next_taken = 1'b1;
            end
            default: begin
                next_pc    = cond_true ? target : pc_seq;
                next_taken = cond_true;
            end
        endcase
    end

    // PC, branch indicator and flags registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc           <= RESET_PC;
            branch_taken <= 1'b0;
            flags        <= '0;
        end else begin
            pc           <= next_pc;
            branch_taken <= next_taken;
            if (status_load) begin
                flags <= flags_t'(alu_flags);
            end
        end
    end

    // Link value, its qualifier, and the status word returned to the decoders
    assign databus_out       = pc_seq;
    assign databus_out_valid = databus_enable;

    always_comb begin
        status                  = '0;
        status[STATUS_V]        = flags.v;
        status[STATUS_C]        = flags.c;
        status[STATUS_N]        = flags.n;
        status[STATUS_Z]        = flags.z;
        status[STATUS_ALU_ZERO] = alu_zero;
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit and its condition_evaluator.
module tb_program_counter_unit;
    import control_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  function_select;
    logic        input_select;
    logic        databus_enable;
    logic [63:0] constant;
    logic [3:0]  condition;
    logic [63:0] databus_in;
    logic        status_load;
    logic [3:0]  alu_flags;
    logic        alu_zero;
    logic [63:0] pc;
    logic [63:0] databus_out;
    logic        databus_out_valid;
    logic [4:0]  status;
    logic        branch_taken;

    logic [3:0]  ce_condition;
    logic [3:0]  ce_flags;
    logic        ce_true;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    program_counter_unit dut (
        .clock             (clock),
        .reset             (reset),
        .function_select   (function_select),
        .input_select      (input_select),
        .databus_enable    (databus_enable),
        .constant          (constant),
        .condition         (condition),
        .databus_in        (databus_in),
        .status_load       (status_load),
        .alu_flags         (alu_flags),
        .alu_zero          (alu_zero),
        .pc                (pc),
        .databus_out       (databus_out),
        .databus_out_valid (databus_out_valid),
        .status            (status),
        .branch_taken      (branch_taken)
    );

    condition_evaluator u_ce (
        .condition (ce_condition),
        .flags     (ce_flags),
        .cond_true (ce_true)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pc(input logic [63:0] addr);
        function_select = PC_LOAD;
        input_select    = 1'b0;
        databus_in      = addr;
        step();
    endtask

    // Reference condition table written from the architectural definitions
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z == 1'b1;
            4'h1: return z == 1'b0;
            4'h2: return cy == 1'b1;
            4'h3: return cy == 1'b0;
            4'h4: return n == 1'b1;
            4'h5: return n == 1'b0;
            4'h6: return v == 1'b1;
            4'h7: return v == 1'b0;
            4'h8: return (cy == 1'b1) && (z == 1'b0);
            4'h9: return !((cy == 1'b1) && (z == 1'b0));
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return (z == 1'b0) && (n == v);
            4'hD: return !((z == 1'b0) && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        reset           = 1'b0;
        function_select = PC_HOLD;
        input_select    = 1'b0;
        databus_enable  = 1'b0;
        constant        = '0;
        condition       = 4'h0;
        databus_in      = '0;
        status_load     = 1'b0;
        alu_flags       = 4'h0;
        alu_zero        = 1'b0;
        ce_condition    = 4'h0;
        ce_flags        = 4'h0;

        // Reset state
        step();
        check("reset_pc", pc, 64'h0);
        check("reset_taken", 64'(branch_taken), 64'h0);
        check("reset_flags", 64'(status[4:1]), 64'h0);

        // Four sequential increments
        reset           = 1'b1;
        function_select = PC_INC;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("inc_pc_%0d", i), pc, 64'(4 * i));
            check($sformatf("inc_taken_%0d", i), 64'(branch_taken), 64'h0);
        end

        // Register-sourced load
        load_pc(64'hDEAD_BEE0);
        check("load_reg_pc", pc, 64'hDEAD_BEE0);
        check("load_reg_taken", 64'(branch_taken), 64'h1);

        // Link value at pc=0x40
        load_pc(64'h40);
        function_select = PC_HOLD;
        databus_enable  = 1'b1;
        step();
        check("hold_pc", pc, 64'h40);
        check("hold_taken", 64'(branch_taken), 64'h0);
        check("link_value", databus_out, 64'h44);
        check("link_valid", 64'(databus_out_valid), 64'h1);
        databus_enable = 1'b0;
        #1;
        check("link_valid_off", 64'(databus_out_valid), 64'h0);

        // Load Z=1 together with pc=0x100
        status_load = 1'b1;
        alu_flags   = 4'b0100;
        load_pc(64'h100);
        status_load = 1'b0;
        check("flags_z_loaded", 64'(status), 64'b00010);

        // EQ taken, constant -2 words
        function_select = PC_COND;
        condition       = EQ;
        input_select    = 1'b1;
        constant        = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        check("eq_taken_pc", pc, 64'hF8);
        check("eq_taken_bt", 64'(branch_taken), 64'h1);

        // NE not taken from 0x100
        load_pc(64'h100);
        function_select = PC_COND;
        condition       = NE;
        input_select    = 1'b1;
        step();
        check("ne_fall_pc", pc, 64'h104);
        check("ne_fall_bt", 64'(branch_taken), 64'h0);

        // Clear flags, then same-cycle flag load and EQ: old flags decide
        function_select = PC_HOLD;
        status_load     = 1'b1;
        alu_flags       = 4'b0000;
        step();
        check("flags_cleared", 64'(status[4:1]), 64'h0);
        function_select = PC_COND;
        condition       = EQ;
        alu_flags       = 4'b0100;
        step();
        status_load     = 1'b0;
        function_select = PC_HOLD;
        check("same_cycle_pc", pc, 64'h108);
        check("same_cycle_bt", 64'(branch_taken), 64'h0);
        check("same_cycle_z", 64'(status[STATUS_Z]), 64'h1);

        // Live alu_zero pass-through
        alu_zero = 1'b1;
        #1;
        check("alu_zero_live", 64'(status[STATUS_ALU_ZERO]), 64'h1);
        alu_zero = 1'b0;

        // Flag ordering: alu {N,Z,C,V}=1001 -> status {V,C,N,Z}=1010
        status_load = 1'b1;
        alu_flags   = 4'b1001;
        step();
        status_load = 1'b0;
        check("flag_order", 64'(status), 64'b10100);

        // Wrap-around
        load_pc(64'hFFFF_FFFF_FFFF_FFFC);
        function_select = PC_INC;
        step();
        check("wrap_pc", pc, 64'h0);
        check("wrap_bt", 64'(branch_taken), 64'h0);

        // Reset during an always-taken branch with a flag load pending
        load_pc(64'h200);
        function_select = PC_COND;
        condition       = AL;
        input_select    = 1'b0;
        databus_in      = 64'h500;
        status_load     = 1'b1;
        alu_flags       = 4'b1111;
        reset           = 1'b0;
        step();
        check("rst_branch_pc", pc, 64'h0);
        check("rst_branch_bt", 64'(branch_taken), 64'h0);
        check("rst_branch_flags", 64'(status[4:1]), 64'h0);
        reset           = 1'b1;
        status_load     = 1'b0;
        function_select = PC_HOLD;

        // Exhaustive condition evaluator
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                ce_condition = 4'(c);
                ce_flags     = 4'(f);
                #1;
                check($sformatf("cond_%0h_flags_%0h", c, f), 64'(ce_true), 64'(cond_ref(4'(c), 4'(f))));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
